// File: rtl/ltc2311_capture.sv
// LTC2311-16 conversion/readout sequencer. It issues a CNV pulse, clocks the result out over
// SCK/SDO, and pushes each sampled word into the sample FIFO at a fixed rate.
module ltc2311_capture #(
    parameter int DATA_WIDTH    = 16,
    parameter int CLK_DIV       = 2,
    parameter int CNV_CYCLES    = 50,
    parameter int SAMPLE_PERIOD = 200
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  adc_sdo,
    input  logic                  full,
    input  logic                  overflow_clear,
    output logic                  adc_cnv,
    output logic                  adc_sck,
    output logic                  write_increment,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  busy,
    output logic                  overflow,
    output logic [2:0]            state_dbg
);
    localparam int CW   = $clog2(SAMPLE_PERIOD);
    localparam int DIVW = $clog2(CLK_DIV + 1);
    localparam int BW   = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0]   CNT_LAST = CW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0]   CNV_LAST = CW'(CNV_CYCLES - 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_PUSH    = 3'd3,
        ST_WAIT    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DIVW-1:0]       div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  cnv_q, cnv_d;
    logic                  sck_q, sck_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // Handshake: write_increment is a single-cycle push, raised only in PUSH while full=0;
    // write_data is valid exactly while write_increment=1 and holds the last pushed word otherwise.
    always_comb begin
        state_d         = state_q;
        div_d           = div_q;
        bit_d           = bit_q;
        sck_d           = 1'b0;
        shreg_d         = shreg_q;
        wdata_d         = wdata_q;
        ovf_d           = overflow_clear ? 1'b0 : ovf_q;
        write_increment = 1'b0;
        write_data      = wdata_q;
        cnt_d           = (state_q == ST_IDLE || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (cnt_q == CNV_LAST) begin
                    state_d = ST_SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_SHIFT: begin
                // One trailing low cycle follows the last bit before PUSH.
                if (bit_q == BIT_LAST) begin
                    state_d = ST_PUSH;
                end else begin
                    sck_d = sck_q;
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        sck_d = ~sck_q;
                        if (sck_q) begin
                            shreg_d = {shreg_q[DATA_WIDTH-2:0], adc_sdo};
                            bit_d   = bit_q + 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            ST_PUSH: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    write_increment = 1'b1;
                    write_data      = shreg_q;
                    wdata_d         = shreg_q;
                end
                if (cnt_q == CNT_LAST) state_d = enable ? ST_CONVERT : ST_IDLE;
                else                   state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) state_d = enable ? ST_CONVERT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cnv_d = (state_d == ST_CONVERT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            cnv_q   <= 1'b0;
            sck_q   <= 1'b0;
            ovf_q   <= 1'b0;
            shreg_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            cnv_q   <= cnv_d;
            sck_q   <= sck_d;
            ovf_q   <= ovf_d;
            shreg_q <= shreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign adc_cnv   = cnv_q;
    assign adc_sck   = sck_q;
    assign overflow  = ovf_q;
    assign state_dbg = state_q;
    assign busy      = (state_q == ST_CONVERT) || (state_q == ST_SHIFT) || (state_q == ST_PUSH);

endmodule

// File: tb/tb_ltc2311_capture.sv
// Directed bench for ltc2311_capture: an LTC2311 SDO model, a push/CNV monitor and
// hand-computed expected words and timings.
module tb_ltc2311_capture;
    localparam int DW = 16;
    localparam int CLK_DIV = 2;
    localparam logic [2:0] S_IDLE = 3'd0, S_SHIFT = 3'd2, S_PUSH = 3'd3, S_WAIT = 3'd4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          adc_sdo = 1'b0;
    logic          full = 1'b0;
    logic          overflow_clear = 1'b0;
    logic          adc_cnv, adc_sck, write_increment, busy, overflow;
    logic [DW-1:0] write_data;
    logic [2:0]    state_dbg;

    ltc2311_capture dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .adc_sdo(adc_sdo),
        .full(full), .overflow_clear(overflow_clear), .adc_cnv(adc_cnv), .adc_sck(adc_sck),
        .write_increment(write_increment), .write_data(write_data), .busy(busy),
        .overflow(overflow), .state_dbg(state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc++;

    // ---------------- ADC model and monitor ----------------
    logic [DW-1:0] adc_word = '0;
    logic [DW-1:0] frame_word = '0;
    bit            inc_mode = 1'b0;
    int            bit_idx = DW - 1;
    logic          cnv_prev = 1'b0, sck_prev = 1'b0;
    int            cnv_len = 0, last_cnv_len = 0, last_cnv_rise = 0;
    int            sck_rises = 0, sck_bad = 0, run_len = 0;
    int            cnv_rise_cnt = 0, push_cyc = 0;
    int            cnv_rise_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];

    always @(negedge clock) begin
        if (!reset_n) begin
            cnv_prev = 1'b0;
            sck_prev = 1'b0;
            run_len  = 0;
        end else begin
            if (adc_cnv && !cnv_prev) begin
                cnv_rise_cnt++;
                cnv_rise_q.push_back(cyc);
                last_cnv_rise = cyc;
                cnv_len = 0;
                sck_rises = 0;
                frame_word = adc_word;
                if (inc_mode) adc_word = adc_word + 1'b1;
                bit_idx = DW - 1;
            end
            if (adc_cnv) cnv_len++;
            if (!adc_cnv && cnv_prev) last_cnv_len = cnv_len;
            if (adc_sck != sck_prev) begin
                if (run_len != CLK_DIV) sck_bad++;
                if (adc_sck) sck_rises++;
                else bit_idx--;
                run_len = 1;
            end else if (cnv_prev && !adc_cnv) begin
                run_len = 1;
            end else begin
                run_len++;
            end
            if (write_increment) begin
                got_q.push_back(write_data);
                push_cyc = cyc;
            end
            cnv_prev = adc_cnv;
            sck_prev = adc_sck;
        end
        adc_sdo = (bit_idx >= 0) ? frame_word[bit_idx] : 1'b0;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        for (int i = 0; i < budget && state_dbg !== s; i++) tick();
        check(tag, state_dbg, s);
    endtask

    task automatic wait_pushes(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && got_q.size() < n; i++) tick();
        check(tag, got_q.size(), n);
    endtask

    task automatic check_words(input string tag);
        while (exp_q.size() > 0 && got_q.size() > 0)
            check(tag, got_q.pop_front(), exp_q.pop_front());
        check({tag, "_left"}, exp_q.size() + got_q.size(), 0);
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- tests ----------------
    initial begin
        int rises_before;
        int n_rise;

        repeat (3) tick();
        check("rst_cnv", adc_cnv, 0);
        check("rst_sck", adc_sck, 0);
        check("rst_wi", write_increment, 0);
        check("rst_wdata", write_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_state", state_dbg, S_IDLE);
        reset_n = 1'b1;
        tick();

        // 1: single frame 0xA5C3
        adc_word = 16'hA5C3;
        enable = 1'b1;
        tick();
        tick();
        check("t1_busy", busy, 1);
        wait_pushes(1, 300, "t1_push_cnt");
        exp_q.push_back(16'hA5C3);
        check_words("t1_word");
        check("t1_latency", push_cyc - last_cnv_rise, 115);
        check("t1_cnv_len", last_cnv_len, 50);
        check("t1_sck_rises", sck_rises, 16);
        check("t1_sck_shape", sck_bad, 0);
        check("t1_wi_pulse", write_increment, 0);
        check("t1_wdata_hold", write_data, 16'hA5C3);
        check("t1_state_wait", state_dbg, S_WAIT);
        check("t1_busy_wait", busy, 0);

        // 2: continuous incrementing words
        inc_mode = 1'b1;
        adc_word = 16'h1000;
        wait_pushes(3, 700, "t2_push_cnt");
        exp_q.push_back(16'h1000);
        exp_q.push_back(16'h1001);
        exp_q.push_back(16'h1002);
        check_words("t2_word");
        n_rise = cnv_rise_q.size();
        check("t2_rise_cnt", n_rise, 4);
        if (n_rise >= 4) begin
            check("t2_period_a", cnv_rise_q[1] - cnv_rise_q[0], 200);
            check("t2_period_b", cnv_rise_q[3] - cnv_rise_q[2], 200);
        end
        check("t2_ovf", overflow, 0);
        check("t2_sck_shape", sck_bad, 0);

        // 3: full through PUSH drops the word
        inc_mode = 1'b0;
        adc_word = 16'h5A5A;
        full = 1'b1;
        rises_before = cnv_rise_cnt;
        for (int i = 0; i < 300 && cnv_rise_cnt == rises_before; i++) tick();
        wait_state(S_WAIT, 200, "t3_reach_wait");
        check("t3_no_push", got_q.size(), 0);
        check("t3_ovf_set", overflow, 1);
        check("t3_wdata_kept", write_data, 16'h1002);
        full = 1'b0;
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("t3_ovf_cleared", overflow, 0);

        // 4: clear coinciding with a drop leaves overflow set
        wait_state(S_SHIFT, 300, "t4_reach_shift");
        full = 1'b1;
        check("t4_ovf_pre", overflow, 0);
        wait_state(S_PUSH, 100, "t4_reach_push");
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        tick();
        check("t4_ovf_wins", overflow, 1);
        check("t4_no_push", got_q.size(), 0);

        // 5: enable dropped mid-SHIFT, frame still completes
        full = 1'b0;
        adc_word = 16'h3C96;
        wait_state(S_SHIFT, 300, "t5_reach_shift");
        enable = 1'b0;
        wait_pushes(1, 200, "t5_push_cnt");
        exp_q.push_back(16'h3C96);
        check_words("t5_word");
        rises_before = cnv_rise_cnt;
        repeat (300) tick();
        check("t5_no_cnv", cnv_rise_cnt - rises_before, 0);
        check("t5_state_idle", state_dbg, S_IDLE);
        check("t5_busy", busy, 0);

        // 6: reset during SHIFT, then restart
        adc_word = 16'h0F0F;
        enable = 1'b1;
        wait_state(S_SHIFT, 100, "t6_reach_shift");
        for (int i = 0; i < 40 && adc_sck !== 1'b1; i++) tick();
        check("t6_sck_high", adc_sck, 1);
        reset_n = 1'b0;
        #1;
        check("t6_sck_drop", adc_sck, 0);
        check("t6_cnv_drop", adc_cnv, 0);
        check("t6_wi_drop", write_increment, 0);
        check("t6_state_rst", state_dbg, S_IDLE);
        adc_word = 16'hC0DE;
        repeat (150) tick();
        check("t6_no_push", got_q.size(), 0);
        check("t6_ovf_rst", overflow, 0);
        reset_n = 1'b1;
        wait_pushes(1, 300, "t6_push_cnt");
        exp_q.push_back(16'hC0DE);
        check_words("t6_word");
        check("t6_latency", push_cyc - last_cnv_rise, 115);
        check("t6_sck_shape", sck_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
